contador: RTL and testbench

- Free-running WIDTH-bit synchronous counter, one clock domain, asynchronous active-high reset.
- One RTL module covers both counter flavours the system instantiates, selected by parameter:
  - Contador1: up-counter, UP=1.
  - Contador2: down-counter, UP=0.
- Leaf block; output drives status/display logic directly. No enable, no load, no handshake.

---
 rtl/contador_pkg.sv | 14 +
 rtl/contador_wrappers.sv | 39 +++
 rtl/contador.sv | 39 +++
 tb/tb_contador.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter family: default width and the
// per-direction reset value.
package contador_pkg;

  localparam int unsigned CNT_W = 4;

  // Up-counters restart from zero, down-counters from all ones.
  function automatic logic [31:0] rst_val(input bit up, input int unsigned width);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF >> (32 - width);
    return up ? 32'd0 : ones;
  endfunction

endpackage

// File: rtl/contador_wrappers.sv
// Fixed-direction counters used across the system: Contador1 counts up,
// Contador2 counts down, both at the default package width.
module Contador1
  import contador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] s
);

  contador #(
    .WIDTH(CNT_W),
    .UP   (1'b1)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .s  (s)
  );

endmodule

module Contador2
  import contador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] s
);

  contador #(
    .WIDTH(CNT_W),
    .UP   (1'b0)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .s  (s)
  );

endmodule

// File: rtl/contador.sv
// Free-running modulo-2^WIDTH counter, direction chosen by UP, with an
// asynchronous active-high reset and the output taken straight from the register.
module contador
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter bit          UP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] s
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(rst_val(UP, WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Unsigned add/subtract wraps naturally at the register width.
  always_comb begin
    cnt_d = cnt_q;
    if (UP) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign s = cnt_q;

endmodule

// File: tb/tb_contador.sv
// Bench for the contador family: up and down 4-bit wrappers plus a 3-bit
// down counter, all sharing clk/rst, checked by vectors and a random model run.
module tb_contador;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] s_up;
  logic [3:0] s_dn;
  logic [2:0] s_w3;

  int total = 0;
  int bad   = 0;
  int n     = 0;  // rising edges seen with rst low since the last reset

  Contador1 u_up (.clk(clk), .rst(rst), .s(s_up));
  Contador2 u_dn (.clk(clk), .rst(rst), .s(s_dn));
  contador #(.WIDTH(3), .UP(1'b0)) u_w3 (.clk(clk), .rst(rst), .s(s_w3));

  typedef struct {
    bit       rst;
    int       edges;
    int       exp_up;
    int       exp_dn;
    int       exp_w3;
  } vec_t;

  vec_t vecs[10];

  // One clock period; outputs are sampled 2 units after the falling edge.
  task automatic tick();
    #3 clk = 1'b1;
    if (rst) n = 0;
    else n = n + 1;
    #5 clk = 1'b0;
    #2;
  endtask

  task automatic cmp(input string name, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: value after k counting edges is k mod 2^W up, (2^W-1) - (k mod 2^W) down.
  function automatic int model(input int width, input bit up, input int k);
    int m;
    m = k % (1 << width);
    return up ? m : ((1 << width) - 1 - m);
  endfunction

  task automatic check_model(input string name);
    cmp({name, "_up"}, int'(s_up), model(4, 1'b1, n));
    cmp({name, "_dn"}, int'(s_dn), model(4, 1'b0, n));
    cmp({name, "_w3"}, int'(s_w3), model(3, 1'b0, n));
  endtask

  initial begin
    vecs[0] = '{1'b1, 0,  0, 15, 7};  // reset hold, no edges
    vecs[1] = '{1'b0, 1,  1, 14, 6};
    vecs[2] = '{1'b0, 1,  2, 13, 5};
    vecs[3] = '{1'b0, 1,  3, 12, 4};
    vecs[4] = '{1'b0, 1,  4, 11, 3};
    vecs[5] = '{1'b0, 1,  5, 10, 2};
    vecs[6] = '{1'b0, 10, 15, 0, 0};  // 15 edges
    vecs[7] = '{1'b0, 1,  0, 15, 7};  // 16th edge wraps
    vecs[8] = '{1'b0, 34, 2, 13, 5};  // 50 edges
    vecs[9] = '{1'b1, 3,  0, 15, 7};  // reset held across edges

    #1 rst = 1'b1;
    #10;
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      if (rst) n = 0;
      for (int e = 0; e < vecs[i].edges; e++) tick();
      cmp($sformatf("vec%0d_up", i), int'(s_up), vecs[i].exp_up);
      cmp($sformatf("vec%0d_dn", i), int'(s_dn), vecs[i].exp_dn);
      cmp($sformatf("vec%0d_w3", i), int'(s_w3), vecs[i].exp_w3);
      $display("vec %0d: rst=%0d edges=%0d up=%0d dn=%0d w3=%0d",
               i, vecs[i].rst, vecs[i].edges, s_up, s_dn, s_w3);
    end

    // Width-3 down sequence from reset: 6..0 then back to 7 on the 8th edge.
    rst = 1'b1;
    #1 rst = 1'b0;
    n = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      cmp($sformatf("w3seq%0d", e), int'(s_w3), (e == 8) ? 7 : 7 - e);
    end

    // Mid-count asynchronous reset between edges.
    rst = 1'b1;
    #1 rst = 1'b0;
    n = 0;
    for (int e = 0; e < 7; e++) tick();
    cmp("mid_pre_up", int'(s_up), 7);
    cmp("mid_pre_dn", int'(s_dn), 8);
    rst = 1'b1;
    #1;
    cmp("mid_async_up", int'(s_up), 0);
    cmp("mid_async_dn", int'(s_dn), 15);
    rst = 1'b0;
    n = 0;
    tick();
    cmp("mid_next_up", int'(s_up), 1);
    cmp("mid_next_dn", int'(s_dn), 14);

    // rst rising together with a clk edge: reset must win.
    for (int e = 0; e < 3; e++) tick();
    #3;
    rst = 1'b1;
    clk = 1'b1;
    #1;
    cmp("coinc_up", int'(s_up), 0);
    cmp("coinc_dn", int'(s_dn), 15);
    #4 clk = 1'b0;
    #2 rst = 1'b0;
    n = 0;

    // Random mix of counting edges, async pulses and reset held over edges.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst = 1'b1;
        n = 0;
        #1 rst = 1'b0;
      end else if (r == 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
